// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared ALU mode encoding and operand geometry legality check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef ALU_PKG_MACROS
`define ALU_PKG_MACROS
// Module-item level: stops elaboration on an illegal WIDTH/BLOCK pairing.
`define ALU_LEGALITY_CHECK(W, B) if ((((W) % (B)) != 0) || ((B) < 2)) begin : g_bad_geometry $error("alu: WIDTH must be a multiple of BLOCK and BLOCK must be >= 2"); end
`endif

package alu_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

`default_nettype wire

// File: rtl/cla_group.sv
// ---------------------------------------------------------------------------
// cla_group : combinational BLOCK-bit carry-lookahead group
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cla_group #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             p,
  output logic             g,
  output logic             c_msb
);

  logic [BLOCK-1:0] w_prop;
  logic [BLOCK-1:0] w_gen;
  logic [BLOCK-1:0] w_carry;
  logic             w_grp_g;
  logic             w_acc;
  logic             w_term;

  assign w_prop = a ^ b;
  assign w_gen  = a & b;

  // Each carry is a flat sum of products over ci and the lower generates.
  always_comb begin
    w_carry = '0;
    w_grp_g = 1'b0;
    w_acc   = 1'b0;
    w_term  = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      w_term = ci;
      for (int j = 0; j < i; j++) w_term = w_term & w_prop[j];
      w_acc = w_term;
      for (int j = 0; j < i; j++) begin
        w_term = w_gen[j];
        for (int k = j + 1; k < i; k++) w_term = w_term & w_prop[k];
        w_acc = w_acc | w_term;
      end
      w_carry[i] = w_acc;
    end
    for (int j = 0; j < BLOCK; j++) begin
      w_term = w_gen[j];
      for (int k = j + 1; k < BLOCK; k++) w_term = w_term & w_prop[k];
      w_grp_g = w_grp_g | w_term;
    end
  end

  assign s     = w_prop ^ w_carry;
  assign p     = &w_prop;
  assign g     = w_grp_g;
  assign c_msb = w_carry[BLOCK-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder : one lookahead group per stage, valid/ready with backpressure
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / BLOCK;

  `ALU_LEGALITY_CHECK(WIDTH, BLOCK)

  logic             w_advance;
  logic             w_is_sub;
  logic [STAGES-1:0] r_valid;

  // Operands shift right by BLOCK per stage so each stage's group sits at bit 0.
  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c [STAGES];

  logic [WIDTH-1:0] w_a_in [STAGES];
  logic [WIDTH-1:0] w_b_in [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic [WIDTH-1:0] w_sum_next [STAGES];
  logic [BLOCK-1:0] w_s [STAGES];
  logic             w_ci [STAGES];
  logic             w_p [STAGES];
  logic             w_g [STAGES];
  logic             w_cmsb [STAGES];
  logic             w_co [STAGES];

  assign w_is_sub  = (mode_e'(sub) == MODE_SUB);
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a_in[k]   = x;
      assign w_b_in[k]   = w_is_sub ? ~y : y;
      assign w_ci[k]     = cin ^ w_is_sub;
      assign w_sum_in[k] = '0;
    end else begin : g_tail
      assign w_a_in[k]   = r_a[k-1];
      assign w_b_in[k]   = r_b[k-1];
      assign w_ci[k]     = r_c[k-1];
      assign w_sum_in[k] = r_sum[k-1];
    end

    cla_group #(
      .BLOCK (BLOCK)
    ) u_group (
      .a     (w_a_in[k][BLOCK-1:0]),
      .b     (w_b_in[k][BLOCK-1:0]),
      .ci    (w_ci[k]),
      .s     (w_s[k]),
      .p     (w_p[k]),
      .g     (w_g[k]),
      .c_msb (w_cmsb[k])
    );

    assign w_co[k] = w_g[k] | (w_p[k] & w_ci[k]);
    // New group enters at the top; after the last stage groups are in order.
    assign w_sum_next[k] = WIDTH'({w_s[k], w_sum_in[k]} >> BLOCK);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) r_valid[k] <= r_valid[k-1];
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= w_a_in[k] >> BLOCK;
        r_b[k]   <= w_b_in[k] >> BLOCK;
        r_sum[k] <= w_sum_next[k];
        r_c[k]   <= w_co[k];
      end
      cout <= w_co[STAGES-1];
      ovf  <= w_co[STAGES-1] ^ w_cmsb[STAGES-1];
      zero <= ~|w_sum_next[STAGES-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_cla_adder : directed self-checking bench for pipelined_cla_adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_cla_adder;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  pipelined_cla_adder #(
    .WIDTH (32),
    .BLOCK (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Returns {cout, ovf, zero, sum} from plain wide arithmetic.
  function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic s);
    logic [31:0] bb;
    logic [32:0] full;
    logic        v;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 33'(s ? !ci : ci);
    v    = (a[31] == bb[31]) && (full[31] != a[31]);
    return {full[32], v, (full[31:0] == 32'd0), full[31:0]};
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input logic s, input logic [31:0] esum,
                        input logic ec, input logic eo, input logic ez);
    int lat;
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    cin       = ci;
    sub       = s;
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_sum"},  64'(sum),  64'(esum));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"},  64'(ovf),  64'(eo));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
    @(posedge clock); #1;
  endtask

  logic [31:0] sx [8];
  logic [31:0] sy [8];
  logic        sc [8];
  logic        ss [8];
  logic [34:0] held;
  logic [34:0] exp_res;
  int          sent;
  int          recv;
  int          cyc;
  int          stale;
  logic        stall;
  logic        took;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;

    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum",       64'(sum),       64'd0);
    check("reset_flags",     64'({cout, ovf, zero}), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    @(posedge clock); #1;
    reset = 1'b0;

    run_op("add_ff_1",    32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("add_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_borrow",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_equal",   32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("add_cin",     32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrowin",32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0);

    // Back-to-back stream with a three-cycle consumer stall once the pipe is full.
    for (int i = 0; i < 8; i++) begin
      sx[i] = $urandom;
      sy[i] = $urandom;
      sc[i] = 1'($urandom_range(0, 1));
      ss[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    recv = 0;
    cyc  = 0;
    held = '0;
    while (recv < 8 && cyc < 40) begin
      stall     = (cyc >= 5) && (cyc < 8);
      out_ready = !stall;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        x   = sx[sent];
        y   = sy[sent];
        cin = sc[sent];
        sub = ss[sent];
      end
      @(negedge clock);
      check("stream_in_ready", 64'(in_ready), 64'(!stall));
      took = in_valid && in_ready;
      if (out_valid) begin
        if (cyc == 5) held = {cout, ovf, zero, sum};
        if (cyc == 6 || cyc == 7) check("stall_hold", 64'({cout, ovf, zero, sum}), 64'(held));
        if (out_ready) begin
          exp_res = ref_op(sx[recv], sy[recv], sc[recv], ss[recv]);
          check("stream_result", 64'({cout, ovf, zero, sum}), 64'(exp_res));
          recv++;
        end
      end
      @(posedge clock); #1;
      if (took) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(recv), 64'd8);

    // Fill the pipe with the consumer stalled, then reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      x        = 32'h1111_1111 * (i + 1);
      y        = 32'h0100_0000;
      cin      = 1'b0;
      sub      = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'(sum),       64'd0);
    check("rst_flags",     64'({cout, ovf, zero}), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clock); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    @(posedge clock); #1;
    run_op("post_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
